scm_access_ctrl: RTL and testbench

SCM_ACCESS_CTRL -- requirements
Module: scm_access_ctrl

---
 rtl/scm_access_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_scm_access_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scm_access_ctrl.sv
// scm_access_ctrl: two-requester access controller for a latch-based SCM.
// The write port and the read port are arbitrated independently, each with
// its own round-robin pointer. Write commands reach the SCM one cycle after
// the grant. Read data returns two cycles after the grant.
// A same-address read is held back behind a write in the same cycle.
// Optional build macro SCM_CTRL_CLEAR_EN adds a clear FSM. The FSM writes
// zero to every row. When the macro is undefined, CLR_START is ignored.
module scm_access_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  REQ_A,
    input  logic                  REQ_B,
    input  logic                  WR_A,
    input  logic                  WR_B,
    input  logic [ADDR_WIDTH-1:0] ADDR_A,
    input  logic [ADDR_WIDTH-1:0] ADDR_B,
    input  logic [DATA_WIDTH-1:0] WDATA_A,
    input  logic [DATA_WIDTH-1:0] WDATA_B,
    output logic                  GNT_A,
    output logic                  GNT_B,
    output logic                  RVALID_A,
    output logic                  RVALID_B,
    output logic [DATA_WIDTH-1:0] RDATA_A,
    output logic [DATA_WIDTH-1:0] RDATA_B,
    input  logic                  CLR_START,
    output logic                  CLR_BUSY,
    output logic                  CLR_DONE,
    output logic                  MEM_WE,
    output logic                  MEM_RE,
    output logic [ADDR_WIDTH-1:0] MEM_WADDR,
    output logic [ADDR_WIDTH-1:0] MEM_RADDR,
    output logic [DATA_WIDTH-1:0] MEM_DIN,
    input  logic [DATA_WIDTH-1:0] MEM_DOUT,
    output logic                  MEM_SE
);

    logic                  clr_active;  // clear sweep owns the write port
    logic [ADDR_WIDTH-1:0] clr_row;     // row the sweep is writing

`ifdef SCM_CTRL_CLEAR_EN
    typedef enum logic [1:0] {
        CLR_IDLE,
        CLR_RUN,
        CLR_FIN
    } clr_state_t;

    clr_state_t            clr_state_q, clr_state_d;
    logic [ADDR_WIDTH-1:0] clr_row_q;

    // Clear FSM state register; the row counter advances only while sweeping
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            clr_state_q <= CLR_IDLE;
            clr_row_q   <= '0;
        end else begin
            clr_state_q <= clr_state_d;
            if (clr_state_q == CLR_RUN)
                clr_row_q <= clr_row_q + ADDR_WIDTH'(1);
            else
                clr_row_q <= '0;
        end
    end

    // Clear FSM next state. The last row is the point where the counter wraps.
    always_comb begin
        clr_state_d = clr_state_q;
        case (clr_state_q)
            CLR_IDLE: if (CLR_START) clr_state_d = CLR_RUN;
            CLR_RUN:  if (&clr_row_q) clr_state_d = CLR_FIN;
            CLR_FIN:  clr_state_d = CLR_IDLE;
            default:  clr_state_d = CLR_IDLE;
        endcase
    end

    assign clr_active = (clr_state_q == CLR_RUN);
    assign clr_row    = clr_row_q;
    assign CLR_BUSY   = clr_active;
    assign CLR_DONE   = (clr_state_q == CLR_FIN);
`else
    logic unused_clr_start;
    assign unused_clr_start = CLR_START;
    assign clr_active       = 1'b0;
    assign clr_row          = '0;
    assign CLR_BUSY         = 1'b0;
    assign CLR_DONE         = 1'b0;
`endif

    // ---------------- arbitration ----------------
    logic grant_en;
    logic wr_elig_a, wr_elig_b, rd_elig_a, rd_elig_b;
    logic raw_a, raw_b;
    logic gnt_wr_a, gnt_wr_b, gnt_rd_a, gnt_rd_b;
    logic wr_ptr_q, rd_ptr_q;  // 0: A has priority, 1: B has priority

    // No grants while reset is held or while the clear sweep owns the SCM.
    assign grant_en  = RSTN & ~clr_active;
    assign wr_elig_a = grant_en & REQ_A & WR_A;
    assign wr_elig_b = grant_en & REQ_B & WR_B;

    // Hold a read back when the other side writes the same row this cycle.
    // The read then sees the new data on a later cycle.
    assign raw_a     = wr_elig_b & (ADDR_B == ADDR_A);
    assign raw_b     = wr_elig_a & (ADDR_A == ADDR_B);
    assign rd_elig_a = grant_en & REQ_A & ~WR_A & ~raw_a;
    assign rd_elig_b = grant_en & REQ_B & ~WR_B & ~raw_b;

    assign gnt_wr_a  = wr_elig_a & (~wr_elig_b | ~wr_ptr_q);
    assign gnt_wr_b  = wr_elig_b & (~wr_elig_a |  wr_ptr_q);
    assign gnt_rd_a  = rd_elig_a & (~rd_elig_b | ~rd_ptr_q);
    assign gnt_rd_b  = rd_elig_b & (~rd_elig_a |  rd_ptr_q);

    assign GNT_A     = gnt_wr_a | gnt_rd_a;
    assign GNT_B     = gnt_wr_b | gnt_rd_b;

    // Round-robin pointers: after any grant, priority passes to the other side
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (gnt_wr_a | gnt_wr_b) wr_ptr_q <= gnt_wr_a;
            if (gnt_rd_a | gnt_rd_b) rd_ptr_q <= gnt_rd_a;
        end
    end

    // ---------------- write path ----------------
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] din_q;

    // Register the granted write, or the clear row, for the SCM next cycle
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            din_q   <= '0;
        end else begin
            we_q <= clr_active | gnt_wr_a | gnt_wr_b;
            if (clr_active) begin
                waddr_q <= clr_row;
                din_q   <= '0;
            end else if (gnt_wr_a) begin
                waddr_q <= ADDR_A;
                din_q   <= WDATA_A;
            end else if (gnt_wr_b) begin
                waddr_q <= ADDR_B;
                din_q   <= WDATA_B;
            end
        end
    end

    assign MEM_WE    = we_q;
    assign MEM_WADDR = waddr_q;
    assign MEM_DIN   = din_q;
    assign MEM_SE    = 1'b0;

    // ---------------- read path ----------------
    // Stage 0: SCM RE cycle. Stage 1: DOUT returns to the requester.
    // rd_src_pipe records the requester for each stage (1 = B).
    logic [1:0]            rd_vld_pipe;
    logic [1:0]            rd_src_pipe;
    logic [ADDR_WIDTH-1:0] raddr_q;

    // Read pipeline. A clear does not flush it. A reset drops in-flight reads.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            rd_vld_pipe <= '0;
            rd_src_pipe <= '0;
            raddr_q     <= '0;
        end else begin
            rd_vld_pipe <= {rd_vld_pipe[0], gnt_rd_a | gnt_rd_b};
            rd_src_pipe <= {rd_src_pipe[0], gnt_rd_b};
            if (gnt_rd_a)
                raddr_q <= ADDR_A;
            else if (gnt_rd_b)
                raddr_q <= ADDR_B;
        end
    end

    assign MEM_RE    = rd_vld_pipe[0];
    assign MEM_RADDR = raddr_q;
    assign RVALID_A  = rd_vld_pipe[1] & ~rd_src_pipe[1];
    assign RVALID_B  = rd_vld_pipe[1] &  rd_src_pipe[1];
    // Read data is zero except during the valid cycle.
    assign RDATA_A   = RVALID_A ? MEM_DOUT : '0;
    assign RDATA_B   = RVALID_B ? MEM_DOUT : '0;

endmodule

// File: tb/tb_scm_access_ctrl.sv
// Testbench for scm_access_ctrl. A small SCM model drives MEM_DOUT. A reference model
// (row array, per-port priority, read-return slots) predicts grants and SCM traffic.
module tb_scm_access_ctrl;
    localparam int AW   = 6;
    localparam int DW   = 64;
    localparam int ROWS = 1 << AW;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          req_a = 1'b0, req_b = 1'b0, wr_a = 1'b0, wr_b = 1'b0;
    logic [AW-1:0] addr_a = '0, addr_b = '0;
    logic [DW-1:0] wdata_a = '0, wdata_b = '0;
    logic          clr_start = 1'b0;
    logic          gnt_a, gnt_b, rvalid_a, rvalid_b, clr_busy, clr_done;
    logic [DW-1:0] rdata_a, rdata_b, mem_din;
    logic          mem_we, mem_re, mem_se;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic [DW-1:0] mem_dout = '0;
    logic [DW-1:0] scm [ROWS];

    always #5 clk = ~clk;

    scm_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK(clk), .RSTN(rstn),
        .REQ_A(req_a), .REQ_B(req_b), .WR_A(wr_a), .WR_B(wr_b),
        .ADDR_A(addr_a), .ADDR_B(addr_b), .WDATA_A(wdata_a), .WDATA_B(wdata_b),
        .GNT_A(gnt_a), .GNT_B(gnt_b), .RVALID_A(rvalid_a), .RVALID_B(rvalid_b),
        .RDATA_A(rdata_a), .RDATA_B(rdata_b),
        .CLR_START(clr_start), .CLR_BUSY(clr_busy), .CLR_DONE(clr_done),
        .MEM_WE(mem_we), .MEM_RE(mem_re), .MEM_WADDR(mem_waddr), .MEM_RADDR(mem_raddr),
        .MEM_DIN(mem_din), .MEM_DOUT(mem_dout), .MEM_SE(mem_se)
    );

    // SCM device: write at the edge, synchronous read
    always @(posedge clk) begin
        if (mem_we) scm[mem_waddr] <= mem_din;
        if (mem_re) mem_dout <= scm[mem_raddr];
    end

    int total = 0;
    int bad   = 0;

    // reference model
    int            m_wptr, m_rptr;           // side holding priority: 0 = A, 1 = B
    logic [DW-1:0] mem_m [ROWS];
    bit            e_we, e_re;
    logic [AW-1:0] e_waddr, e_raddr;
    logic [DW-1:0] e_din;
    bit            p_v, p_src, o_v, o_src;   // read granted last cycle / two cycles ago
    logic [DW-1:0] p_data, o_data;

    function automatic int pick(bit a, bit b, int ptr);
        if (a && b) return ptr;
        if (a) return 0;
        if (b) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_wptr = 0; m_rptr = 0;
        e_we = 0; e_re = 0; p_v = 0; o_v = 0;
    endtask

    // One clock cycle. Entered and left at posedge+1, with inputs already driven.
    task automatic run_cycle(output bit ga, output bit gb);
        int ww, rw;
        bit wa, wb, ra, rb;
        logic [DW-1:0] got;
        total++;
        if (mem_we !== e_we) begin
            bad++; $display("FAIL mem_we got=%0b want=%0b t=%0t", mem_we, e_we, $time);
        end
        if (e_we) begin
            total++;
            if (mem_waddr !== e_waddr || mem_din !== e_din) begin
                bad++; $display("FAIL mem_wr got=%0d/%0h want=%0d/%0h", mem_waddr, mem_din, e_waddr, e_din);
            end
        end
        total++;
        if (mem_re !== e_re || (e_re && mem_raddr !== e_raddr)) begin
            bad++; $display("FAIL mem_rd got=%0b/%0d want=%0b/%0d", mem_re, mem_raddr, e_re, e_raddr);
        end
        total++;
        if ({rvalid_a, rvalid_b} !== {o_v && !o_src, o_v && o_src}) begin
            bad++; $display("FAIL rvalid got=%b%b want=%b%b", rvalid_a, rvalid_b, o_v && !o_src, o_v && o_src);
        end
        if (o_v) begin
            got = o_src ? rdata_b : rdata_a;
            total++;
            if (got !== o_data) begin
                bad++; $display("FAIL rdata got=%0h want=%0h", got, o_data);
            end
        end
        #1;
        wa = req_a && wr_a;
        wb = req_b && wr_b;
        ra = req_a && !wr_a && !(wb && addr_b == addr_a);
        rb = req_b && !wr_b && !(wa && addr_a == addr_b);
        ww = pick(wa, wb, m_wptr);
        rw = pick(ra, rb, m_rptr);
        ga = (ww == 0) || (rw == 0);
        gb = (ww == 1) || (rw == 1);
        total++;
        if ({gnt_a, gnt_b} !== {ga, gb}) begin
            bad++; $display("FAIL gnt got=%b%b want=%b%b t=%0t", gnt_a, gnt_b, ga, gb, $time);
        end
        o_v = p_v; o_src = p_src; o_data = p_data;
        p_v = (rw >= 0);
        if (rw >= 0) begin
            p_src   = (rw == 1);
            e_raddr = (rw == 1) ? addr_b : addr_a;
            p_data  = mem_m[e_raddr];
            m_rptr  = 1 - rw;
        end
        e_re = p_v;
        e_we = (ww >= 0);
        if (ww >= 0) begin
            e_waddr = (ww == 1) ? addr_b : addr_a;
            e_din   = (ww == 1) ? wdata_b : wdata_a;
            mem_m[e_waddr] = e_din;
            m_wptr  = 1 - ww;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(int n);
        bit ga, gb;
        req_a = 0; req_b = 0;
        repeat (n) run_cycle(ga, gb);
    endtask

    task automatic test_reset();
        bit ga, gb;
        req_a = 1; wr_a = 1; addr_a = 6'd1; wdata_a = 64'h1111;
        req_b = 1; wr_b = 0; addr_b = 6'd2; rstn = 0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({gnt_a, gnt_b, rvalid_a, rvalid_b, clr_busy, clr_done, mem_we, mem_re, mem_se} !== 9'd0) begin
            bad++; $display("FAIL reset_ctl got=%b", {gnt_a, gnt_b, rvalid_a, rvalid_b, clr_busy, clr_done, mem_we, mem_re, mem_se});
        end
        total++;
        if ((rdata_a | rdata_b | mem_din) !== '0 || (mem_waddr | mem_raddr) !== '0) begin
            bad++; $display("FAIL reset_data got=%0h/%0h/%0h", rdata_a, rdata_b, mem_din);
        end
        rstn = 1; model_reset();
        // both pointers start on A
        req_b = 1; wr_b = 1; addr_b = 6'd2; wdata_b = 64'h2222;
        #1;
        total++;
        if ({gnt_a, gnt_b} !== 2'b10) begin
            bad++; $display("FAIL reset_wptr got=%b%b want=10", gnt_a, gnt_b);
        end
        run_cycle(ga, gb); if (ga) req_a = 0; if (gb) req_b = 0;
        run_cycle(ga, gb); if (ga) req_a = 0; if (gb) req_b = 0;
        req_a = 1; wr_a = 0; addr_a = 6'd1;
        req_b = 1; wr_b = 0; addr_b = 6'd2;
        #1;
        total++;
        if ({gnt_a, gnt_b} !== 2'b10) begin
            bad++; $display("FAIL reset_rptr got=%b%b want=10", gnt_a, gnt_b);
        end
        for (int i = 0; i < 4; i++) begin
            run_cycle(ga, gb); if (ga) req_a = 0; if (gb) req_b = 0;
        end
        idle(3);
    endtask

    task automatic test_sweep();
        bit ga, gb;
        for (int i = 0; i < ROWS; i++) begin
            req_a = 1; wr_a = 1; addr_a = AW'(i); wdata_a = {$urandom, $urandom};
            run_cycle(ga, gb);
        end
        idle(3);
    endtask

    task automatic test_write_read();
        bit ga, gb;
        req_a = 1; wr_a = 1; addr_a = 6'd5; wdata_a = 64'hDEADBEEF;
        run_cycle(ga, gb);
        req_a = 0;
        total++;
        if (mem_we !== 1'b1 || mem_waddr !== 6'd5 || mem_din !== 64'hDEADBEEF) begin
            bad++; $display("FAIL wr_n1 got=%b/%0d/%0h", mem_we, mem_waddr, mem_din);
        end
        req_b = 1; wr_b = 0; addr_b = 6'd5;
        run_cycle(ga, gb);
        req_b = 0;
        run_cycle(ga, gb);
        total++;
        if (rvalid_b !== 1'b1 || rdata_b !== 64'hDEADBEEF) begin
            bad++; $display("FAIL rd_n2 got=%b/%0h want=1/deadbeef", rvalid_b, rdata_b);
        end
        idle(3);
    endtask

    task automatic test_raw();
        bit ga, gb;
        req_a = 1; wr_a = 1; addr_a = 6'd3; wdata_a = 64'h1234;
        req_b = 1; wr_b = 0; addr_b = 6'd3;
        #1;
        total++;
        if ({gnt_a, gnt_b} !== 2'b10) begin
            bad++; $display("FAIL raw_hold got=%b%b want=10", gnt_a, gnt_b);
        end
        run_cycle(ga, gb);
        req_a = 0;
        #1;
        total++;
        if (gnt_b !== 1'b1) begin
            bad++; $display("FAIL raw_next got=%b want=1", gnt_b);
        end
        run_cycle(ga, gb);
        req_b = 0;
        run_cycle(ga, gb);
        total++;
        if (rvalid_b !== 1'b1 || rdata_b !== 64'h1234) begin
            bad++; $display("FAIL raw_data got=%b/%0h want=1/1234", rvalid_b, rdata_b);
        end
        idle(3);
    endtask

    task automatic test_back_to_back();
        bit ga, gb, prev_a;
        int hits = 0;
        rstn = 0; @(posedge clk); #1; rstn = 1; model_reset();
        req_a = 1; wr_a = 1; addr_a = AW'($urandom); wdata_a = {$urandom, $urandom};
        req_b = 1; wr_b = 1; addr_b = AW'($urandom); wdata_b = {$urandom, $urandom};
        for (int i = 0; i < 16; i++) begin
            #1;
            total++;
            if (gnt_a !== ((i % 2) == 0) || gnt_b !== ((i % 2) == 1) || (i > 0 && gnt_a === prev_a)) begin
                bad++; $display("FAIL b2b_alt cyc=%0d got=%b%b", i, gnt_a, gnt_b);
            end
            prev_a = gnt_a;
            run_cycle(ga, gb);
            if (mem_we === 1'b1) hits++;
            if (ga) begin addr_a = AW'($urandom); wdata_a = {$urandom, $urandom}; end
            if (gb) begin addr_b = AW'($urandom); wdata_b = {$urandom, $urandom}; end
        end
        total++;
        if (hits != 16) begin
            bad++; $display("FAIL b2b_we got=%0d want=16", hits);
        end
        idle(3);
    endtask

    task automatic test_random();
        bit ga, gb;
        for (int i = 0; i < 400; i++) begin
            if (!req_a && $urandom_range(0, 9) < 7) begin
                req_a = 1; wr_a = 1'($urandom_range(0, 1)); addr_a = AW'($urandom_range(0, 7));
                wdata_a = {$urandom, $urandom};
            end
            if (!req_b && $urandom_range(0, 9) < 7) begin
                req_b = 1; wr_b = 1'($urandom_range(0, 1)); addr_b = AW'($urandom_range(0, 7));
                wdata_b = {$urandom, $urandom};
            end
            run_cycle(ga, gb);
            if (ga) req_a = 0;
            if (gb) req_b = 0;
        end
        idle(3);
    endtask

`ifdef SCM_CTRL_CLEAR_EN
    task automatic test_clear();
        bit ga, gb, gnt_seen = 0, drop = 0;
        int busy = 0, done = 0, wes = 0, rvs = 0, gcyc = -10;
        clr_start = 1;
        @(posedge clk); #1;
        clr_start = 0;
        req_b = 1; wr_b = 0; addr_b = AW'(ROWS - 1);
        for (int c = 0; c < 100; c++) begin
            if (drop) begin req_b = 0; drop = 0; end
            #1;
            if (clr_busy === 1'b1) busy++;
            if (clr_done === 1'b1) done++;
            if (clr_busy === 1'b1 && (gnt_a === 1'b1 || gnt_b === 1'b1)) begin
                total++; bad++; $display("FAIL clr_gnt cyc=%0d", c);
            end
            if (mem_we === 1'b1) begin
                total++;
                if (mem_waddr !== AW'(wes) || mem_din !== '0) begin
                    bad++; $display("FAIL clr_row got=%0d/%0h want=%0d/0", mem_waddr, mem_din, wes);
                end
                wes++;
            end
            if (gnt_b === 1'b1) begin gnt_seen = 1; gcyc = c; drop = 1; end
            if (rvalid_b === 1'b1) begin
                rvs++;
                total++;
                if (rdata_b !== '0 || c != gcyc + 2) begin
                    bad++; $display("FAIL clr_read got=%0h cyc=%0d want=0 cyc=%0d", rdata_b, c, gcyc + 2);
                end
            end
            @(posedge clk); #1;
        end
        total++;
        if (busy != ROWS || done != 1 || wes != ROWS || rvs != 1 || !gnt_seen) begin
            bad++; $display("FAIL clr_counts busy=%0d done=%0d we=%0d rv=%0d want=%0d/1/%0d/1", busy, done, wes, rvs, ROWS, ROWS);
        end
        req_b = 0;
        for (int i = 0; i < ROWS; i++) mem_m[i] = '0;
        m_rptr = 0; e_we = 0; e_re = 0; p_v = 0; o_v = 0;
        for (int i = 0; i < 8; i++) begin
            req_a = 1; wr_a = 0; addr_a = AW'($urandom);
            run_cycle(ga, gb);
        end
        idle(3);
    endtask

    task automatic test_reset_mid_clear();
        bit ga, gb;
        clr_start = 1;
        @(posedge clk); #1;
        clr_start = 0;
        req_a = 1; wr_a = 1; addr_a = 6'd9; wdata_a = 64'hCAFE;
        for (int k = 0; k < 19; k++) begin
            #1;
            total++;
            if (gnt_a !== 1'b0 || clr_busy !== 1'b1) begin
                bad++; $display("FAIL mid_busy k=%0d gnt=%b busy=%b", k, gnt_a, clr_busy);
            end
            @(posedge clk); #1;
        end
        rstn = 0;
        @(posedge clk); #1;
        total++;
        if ({gnt_a, gnt_b, rvalid_a, rvalid_b, clr_busy, clr_done, mem_we, mem_re, mem_se} !== 9'd0 ||
            (rdata_a | rdata_b | mem_din) !== '0 || (mem_waddr | mem_raddr) !== '0) begin
            bad++; $display("FAIL mid_reset got=%b", {gnt_a, gnt_b, rvalid_a, rvalid_b, clr_busy, clr_done, mem_we, mem_re, mem_se});
        end
        rstn = 1; model_reset();
        run_cycle(ga, gb);
        req_a = 0;
        req_b = 1; wr_b = 0; addr_b = 6'd9;
        run_cycle(ga, gb);
        req_b = 0;
        for (int i = 0; i < 80; i++) begin
            run_cycle(ga, gb);
            total++;
            if (clr_done !== 1'b0 || clr_busy !== 1'b0) begin
                bad++; $display("FAIL mid_after cyc=%0d done=%b busy=%b", i, clr_done, clr_busy);
            end
        end
    endtask
`else
    task automatic test_clear_disabled();
        bit ga, gb;
        req_a = 0; req_b = 0;
        clr_start = 1;
        run_cycle(ga, gb);
        clr_start = 0;
        for (int i = 0; i < 70; i++) begin
            run_cycle(ga, gb);
            total++;
            if ({mem_we, clr_busy, clr_done} !== 3'b000) begin
                bad++; $display("FAIL clr_off cyc=%0d got=%b want=000", i, {mem_we, clr_busy, clr_done});
            end
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_sweep();
        test_write_read();
        test_raw();
        test_back_to_back();
        test_random();
`ifdef SCM_CTRL_CLEAR_EN
        test_clear();
        test_reset_mid_clear();
`else
        test_clear_disabled();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
